tx_stream_sink: RTL and testbench

Receiving end of the transmitter streams (tx_freq, tx_am, tx_ctl) that the user design emits over 32-bit stb/ack handshakes. It buffers amplitude samples in a FIFO and holds frequency and control words in pending registers. All updates are applied to the NCO/modulator control outputs only on the sample tick, so frequency, amplitude and mode change coherently at sample boundaries. It also flags FIFO underrun to the status logic.

---
 rtl/tx_sink_pkg.sv | 8 +
 rtl/sync_fifo.sv | 40 ++++
 rtl/tx_stream_sink.sv | 103 ++++++++++
 tb/tb_tx_stream_sink.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/tx_sink_pkg.sv
// tx_sink_pkg: shared constants and types for the transmitter stream sink
package tx_sink_pkg;
    localparam int CTL_ENABLE_BIT = 0;
    localparam int CTL_FM_BIT = 1;
    localparam int CTL_FLUSH_BIT = 2;
    localparam int DATA_W = 32;
    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} pend_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with flush and a registered not_full flag
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      level,
    output logic             not_full
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    logic [AW:0] level_nxt;
    assign do_push = push & ~flush;
    assign do_pop = pop & ~flush & (level != '0);
    assign level_nxt = flush ? '0 : level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    // not_full tracks the next level so a full FIFO never sees an extra ack
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
            not_full <= 1'b0;
        end else begin
            wr_ptr <= flush ? '0 : wr_ptr + AW'(do_push);
            rd_ptr <= flush ? '0 : rd_ptr + AW'(do_pop);
            level <= level_nxt;
            not_full <= level_nxt != (AW+1)'(DEPTH);
        end
endmodule

// File: rtl/tx_stream_sink.sv
// tx_stream_sink: buffers amplitude samples and pending freq/ctl words,
// applying them coherently to the modulator outputs on each sample tick.
module tx_stream_sink
    import tx_sink_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AM_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         in_freq,
    input  logic                      in_freq_stb,
    output logic                      in_freq_ack,
    input  logic [DATA_W-1:0]         in_am,
    input  logic                      in_am_stb,
    output logic                      in_am_ack,
    input  logic [DATA_W-1:0]         in_ctl,
    input  logic                      in_ctl_stb,
    output logic                      in_ctl_ack,
    input  logic                      sample_tick,
    input  logic                      underrun_clr,
    output logic [DATA_W-1:0]         frequency,
    output logic [AM_WIDTH-1:0]       amplitude,
    output logic                      tx_enable,
    output logic                      fm_mode,
    output logic                      underrun,
    output logic [CNT_WIDTH-1:0]      underrun_count,
    output logic [$clog2(DEPTH):0]    fifo_level
);
    pend_state_t freq_st, ctl_st;
    logic [DATA_W-1:0] pend_freq;
    logic [2:0] pend_ctl;
    logic [AM_WIDTH-1:0] fifo_dout;
    logic freq_xfer, ctl_xfer, am_xfer, ctl_apply, eff_en, flush, live, pop, ur;
    logic unused_bits;
    assign unused_bits = ^{in_ctl[DATA_W-1:3], in_am[DATA_W-1:AM_WIDTH]};
    assign freq_xfer = in_freq_stb & in_freq_ack;
    assign ctl_xfer = in_ctl_stb & in_ctl_ack;
    assign am_xfer = in_am_stb & in_am_ack;
    assign ctl_apply = sample_tick && ctl_st == PENDING;
    assign eff_en = ctl_apply ? pend_ctl[CTL_ENABLE_BIT] : tx_enable;
    assign flush = ctl_apply & pend_ctl[CTL_FLUSH_BIT];
    assign live = sample_tick & ~flush & eff_en;
    assign pop = live & (fifo_level != '0);
    assign ur = live & (fifo_level == '0);

    sync_fifo #(.WIDTH(AM_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(am_xfer), .pop(pop), .flush(flush),
        .din(in_am[AM_WIDTH-1:0]), .dout(fifo_dout), .level(fifo_level), .not_full(in_am_ack)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            freq_st <= IDLE;
            in_freq_ack <= 1'b0;
            pend_freq <= '0;
            frequency <= '0;
        end else if (freq_st == IDLE) begin
            in_freq_ack <= ~freq_xfer;
            if (freq_xfer) begin
                pend_freq <= in_freq;
                freq_st <= PENDING;
            end
        end else if (sample_tick) begin
            frequency <= pend_freq;
            freq_st <= IDLE;
            in_freq_ack <= 1'b1;
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            ctl_st <= IDLE;
            in_ctl_ack <= 1'b0;
            pend_ctl <= '0;
            tx_enable <= 1'b0;
            fm_mode <= 1'b0;
        end else if (ctl_st == IDLE) begin
            in_ctl_ack <= ~ctl_xfer;
            if (ctl_xfer) begin
                pend_ctl <= in_ctl[2:0];
                ctl_st <= PENDING;
            end
        end else if (sample_tick) begin
            tx_enable <= pend_ctl[CTL_ENABLE_BIT];
            fm_mode <= pend_ctl[CTL_FM_BIT];
            ctl_st <= IDLE;
            in_ctl_ack <= 1'b1;
        end

    // a fresh underrun outranks a simultaneous clear
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            amplitude <= '0;
            underrun <= 1'b0;
            underrun_count <= '0;
        end else begin
            amplitude <= (sample_tick & ~eff_en) | flush ? '0 : pop ? fifo_dout : amplitude;
            underrun <= ur | (underrun & ~underrun_clr);
            underrun_count <= ur ? (underrun_clr ? CNT_WIDTH'(1) : underrun_count + CNT_WIDTH'(~&underrun_count))
                            : underrun_clr ? '0 : underrun_count;
        end
endmodule

// File: tb/tb_tx_stream_sink.sv
// tb_tx_stream_sink: directed and random stimulus against a queue-based reference model
module tb_tx_stream_sink;
    localparam int DEPTH = 16;
    localparam int AM_WIDTH = 8;
    localparam int CNT_WIDTH = 16;

    logic clk = 1'b0, rst = 1'b0;
    logic [31:0] in_freq = '0, in_am = '0, in_ctl = '0;
    logic in_freq_stb = 1'b0, in_am_stb = 1'b0, in_ctl_stb = 1'b0;
    logic sample_tick = 1'b0, underrun_clr = 1'b0;
    logic in_freq_ack, in_am_ack, in_ctl_ack, tx_enable, fm_mode, underrun;
    logic [31:0] frequency;
    logic [AM_WIDTH-1:0] amplitude;
    logic [CNT_WIDTH-1:0] underrun_count;
    logic [$clog2(DEPTH):0] fifo_level;

    tx_stream_sink #(.DEPTH(DEPTH), .AM_WIDTH(AM_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_freq(in_freq), .in_freq_stb(in_freq_stb), .in_freq_ack(in_freq_ack),
        .in_am(in_am), .in_am_stb(in_am_stb), .in_am_ack(in_am_ack),
        .in_ctl(in_ctl), .in_ctl_stb(in_ctl_stb), .in_ctl_ack(in_ctl_ack),
        .sample_tick(sample_tick), .underrun_clr(underrun_clr),
        .frequency(frequency), .amplitude(amplitude), .tx_enable(tx_enable), .fm_mode(fm_mode),
        .underrun(underrun), .underrun_count(underrun_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    logic [7:0] q[$];
    logic [31:0] m_freq, p_freq;
    logic [2:0] p_ctl;
    bit f_pend, c_pend, m_en, m_fm, m_ur, alive;
    logic [7:0] m_amp;
    int m_cnt;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_freq = '0; p_freq = '0; p_ctl = '0; m_amp = '0; m_cnt = 0;
        f_pend = 0; c_pend = 0; m_en = 0; m_fm = 0; m_ur = 0; alive = 0;
    endtask

    task automatic check_all();
        check("freq_ack", {31'd0, in_freq_ack}, {31'd0, alive && !f_pend});
        check("am_ack", {31'd0, in_am_ack}, {31'd0, alive && q.size() < DEPTH});
        check("ctl_ack", {31'd0, in_ctl_ack}, {31'd0, alive && !c_pend});
        check("frequency", frequency, m_freq);
        check("amplitude", {24'd0, amplitude}, {24'd0, m_amp});
        check("tx_enable", {31'd0, tx_enable}, {31'd0, m_en});
        check("fm_mode", {31'd0, fm_mode}, {31'd0, m_fm});
        check("underrun", {31'd0, underrun}, {31'd0, m_ur});
        check("underrun_count", {16'd0, underrun_count}, m_cnt);
        check("fifo_level", {27'd0, fifo_level}, q.size());
    endtask

    task automatic clear_inputs();
        sample_tick = 0; underrun_clr = 0;
        in_am_stb = 0; in_freq_stb = 0; in_ctl_stb = 0;
    endtask

    task automatic apply_reset();
        rst = 0;
        clear_inputs();
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1;
        #1;
        check_all();
        @(posedge clk);
        #1;
        alive = 1;
        check_all();
    endtask

    task automatic cycle(bit tk, bit clr, bit as, logic [31:0] ad, bit fs, logic [31:0] fd, bit cs, logic [31:0] cd);
        bit xa, xf, xc, fl, ev;
        @(negedge clk);
        sample_tick = tk; underrun_clr = clr;
        in_am_stb = as; in_am = ad;
        in_freq_stb = fs; in_freq = fd;
        in_ctl_stb = cs; in_ctl = cd;
        xa = as && q.size() < DEPTH;
        xf = fs && !f_pend;
        xc = cs && !c_pend;
        fl = 0; ev = 0;
        if (tk) begin
            if (f_pend) begin m_freq = p_freq; f_pend = 0; end
            if (c_pend) begin m_en = p_ctl[0]; m_fm = p_ctl[1]; fl = p_ctl[2]; c_pend = 0; end
            if (fl) begin q.delete(); m_amp = 0; end
            else if (!m_en) m_amp = 0;
            else if (q.size() > 0) m_amp = q.pop_front();
            else ev = 1;
        end
        if (xf) begin p_freq = fd; f_pend = 1; end
        if (xc) begin p_ctl = cd[2:0]; c_pend = 1; end
        if (xa && !fl) q.push_back(ad[7:0]);
        if (ev) begin
            m_ur = 1;
            m_cnt = clr ? 1 : (m_cnt == 65535 ? m_cnt : m_cnt + 1);
        end else if (clr) begin
            m_ur = 0; m_cnt = 0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(int n, bit tk);
        for (int i = 0; i < n; i++) cycle(tk, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        apply_reset();
        // basic pushes with enable, then three ticks
        cycle(0, 0, 1, 32'hAB11, 0, 0, 1, 32'h1);
        cycle(0, 0, 1, 32'hCD22, 0, 0, 0, 0);
        cycle(0, 0, 1, 32'h33, 0, 0, 0, 0);
        idle(3, 1);
        idle(1, 0);
        // fill beyond depth, hold the extra word until a tick frees a slot
        for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, 1, 32'h40 + i, 0, 0, 0, 0);
        cycle(1, 0, 1, 32'h99, 0, 0, 0, 0);
        cycle(0, 0, 1, 32'h99, 0, 0, 0, 0);
        cycle(0, 0, 1, 32'h9A, 0, 0, 0, 0);
        // freq pending/hold
        cycle(0, 0, 0, 0, 1, 32'h0100_0000, 0, 0);
        cycle(0, 0, 0, 0, 1, 32'h0200_0000, 0, 0);
        cycle(1, 0, 0, 0, 1, 32'h0200_0000, 0, 0);
        cycle(0, 0, 0, 0, 1, 32'h0200_0000, 0, 0);
        idle(1, 1);
        // flush with a coincident push, then underruns and clear
        cycle(0, 0, 0, 0, 0, 0, 1, 32'h5);
        cycle(1, 0, 1, 32'h77, 0, 0, 0, 0);
        idle(3, 1);
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 1, 32'h66, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        // flush after five pushes, FM mode, then disable
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 32'h10 + i, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 32'h7);
        idle(2, 1);
        cycle(0, 0, 1, 32'h55, 0, 0, 1, 32'h0);
        idle(2, 1);
        // mid-stream reset with data and a pending freq
        cycle(0, 0, 0, 0, 0, 0, 1, 32'h1);
        idle(1, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 32'h20 + i, i == 0, 32'h1234_5678, 0, 0);
        #2;
        apply_reset();
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] cd;
            cd = $urandom & ~32'h5;
            if ($urandom_range(0, 15) == 0) cd |= 32'h4;
            if ($urandom_range(0, 3) != 0) cd |= 32'h1;
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 1) == 1, $urandom,
                  $urandom_range(0, 3) == 0, $urandom,
                  $urandom_range(0, 7) == 0, cd);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
